vga_sram_display: RTL and testbench

- Self-contained frame-buffer display block for 640x480@60 VGA.
- After reset it fills an external asynchronous SRAM with a generated test pattern, one pixel per 16-bit word.
- It then streams the SRAM contents continuously to 12-bit RGB VGA outputs.
- It sits between the board-level SRAM pins and the VGA connector; everything runs on one system clock with an internal pixel-clock enable.

---
 rtl/vga_sram_display_if.sv | 12 +
 rtl/vga_sram_display.sv | 209 ++++++++++++++++++++
 tb/tb_vga_sram_display.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_sram_display_if.sv
// Video output bundle of vga_sram_display: 4-bit RGB plus active-low syncs.
// master drives the connector pins, slave observes them.
interface vga_sram_display_if;
  logic [3:0] vga_red;
  logic [3:0] vga_green;
  logic [3:0] vga_blue;
  logic       vga_hsync;
  logic       vga_vsync;

  modport master (output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync);
  modport slave  (input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync);
endinterface

// File: rtl/vga_sram_display.sv
// Fills an async SRAM with a generated test pattern after reset, then streams it to VGA forever.
// Optional: define VGA_SRAM_BORDER_EN to force a white one-pixel border over the visible frame.
module vga_sram_display #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int PIXEL_DIV      = 4,
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic [AXI_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [AXI_DATA_WIDTH-1:0] sram_data,
  output logic                      sram_we_n,
  output logic                      sram_oe_n,
  output logic                      sram_ce_n,
  vga_sram_display_if.master        vga,
  output logic                      fill_done
);
  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int DW    = AXI_DATA_WIDTH;
  localparam int DIV_W = (PIXEL_DIV > 2) ? $clog2(PIXEL_DIV) : 2;

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [AW-1:0]    FILL_END   = AW'(H_VISIBLE * V_VISIBLE);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIXEL_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(1);

  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_DISPLAY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             phase_q, phase_d;
  logic [9:0]       fx_q, fx_d, fy_q, fy_d;
  logic [AW-1:0]    fill_p_q, fill_p_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             drive_q, drive_d;
  logic             we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hc_q, hc_d, vc_q, vc_d;
  logic [11:0]      pix_q, pix_d, rgb_q, rgb_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;

  logic             tick;
  logic             visible;
  logic             border;
  logic [11:0]      pattern;
  logic [AW-1:0]    disp_addr;
  logic             unused_data_hi;

  assign tick      = (div_q == DIV_LAST);
  assign visible   = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign disp_addr = AW'(vc_q) * AW'(H_VISIBLE) + AW'(hc_q);
  assign pattern   = {fx_q[6:3], fy_q[6:3], fx_q[6:3] ^ fy_q[6:3]};

`ifdef VGA_SRAM_BORDER_EN
  assign border = visible && ((hc_q == 10'd0) || (hc_q == H_VIS - 10'd1) ||
                              (vc_q == 10'd0) || (vc_q == V_VIS - 10'd1));
`else
  assign border = 1'b0;
`endif

  // Fill writes take two cycles (A: we_n low, B: we_n high) with address and data held.
  // Display reads: address moves one clk after the tick, data is captured one clk later,
  // and the finished pixel with its syncs is presented on the following tick.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    fill_p_d = fill_p_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    drive_d  = drive_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    ce_n_d   = ce_n_q;
    done_d   = done_q;
    div_d    = div_q;
    hc_d     = hc_q;
    vc_d     = vc_q;
    pix_d    = pix_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;

    case (state_q)
      ST_FILL: begin
        if (!phase_q) begin
          if (fill_p_q == FILL_END) begin
            state_d = ST_DISPLAY;
            drive_d = 1'b0;
            we_n_d  = 1'b1;
            oe_n_d  = 1'b0;
            ce_n_d  = 1'b0;
            done_d  = 1'b1;
            div_d   = '0;
            hc_d    = 10'd0;
            vc_d    = 10'd0;
          end else begin
            addr_d  = fill_p_q;
            wdata_d = DW'(pattern);
            drive_d = 1'b1;
            we_n_d  = 1'b0;
            oe_n_d  = 1'b1;
            ce_n_d  = 1'b0;
            phase_d = 1'b1;
          end
        end else begin
          we_n_d   = 1'b1;
          phase_d  = 1'b0;
          fill_p_d = fill_p_q + 1'b1;
          if (fx_q == H_VIS - 10'd1) begin
            fx_d = 10'd0;
            fy_d = fy_q + 10'd1;
          end else begin
            fx_d = fx_q + 10'd1;
          end
        end
      end
      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (visible) addr_d = disp_addr;
        if (div_q == DIV_SAMPLE) pix_d = sram_data[11:0];
        if (tick) begin
          hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
          if (hc_q == H_LAST) vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
          rgb_d   = !visible ? 12'h000 : (border ? 12'hFFF : pix_q);
          hsync_d = !((hc_q >= HS_START) && (hc_q < HS_END));
          vsync_d = !((vc_q >= VS_START) && (vc_q < VS_END));
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FILL;
      phase_q  <= 1'b0;
      fx_q     <= 10'd0;
      fy_q     <= 10'd0;
      fill_p_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      drive_q  <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      done_q   <= 1'b0;
      div_q    <= '0;
      hc_q     <= 10'd0;
      vc_q     <= 10'd0;
      pix_q    <= 12'h000;
      rgb_q    <= 12'h000;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
      fill_p_q <= fill_p_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      drive_q  <= drive_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      ce_n_q   <= ce_n_d;
      done_q   <= done_d;
      div_q    <= div_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      pix_q    <= pix_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign sram_data      = drive_q ? wdata_q : 'z;
  assign unused_data_hi = ^(sram_data >> 12);

  assign sram_addr     = addr_q;
  assign sram_we_n     = we_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_ce_n     = ce_n_q;
  assign fill_done     = done_q;
  assign vga.vga_red   = rgb_q[11:8];
  assign vga.vga_green = rgb_q[7:4];
  assign vga.vga_blue  = rgb_q[3:0];
  assign vga.vga_hsync = hsync_q;
  assign vga.vga_vsync = vsync_q;
endmodule

// File: tb/tb_vga_sram_display.sv
// Bench for vga_sram_display on a shrunken 32x16 raster so fill plus three frames stay short.
// Expected video is computed from pixel coordinates; the SRAM model stores whatever the DUT writes.
module tb_vga_sram_display;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int PD = 4;
  localparam int HV = 32;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VV = 16;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int NPIX = HV * VV;
  localparam int AIDX = $clog2(NPIX);
  localparam int FRAME_EDGES = HT * VT * PD;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [AW-1:0] sram_addr;
  tri1  [DW-1:0] sram_data;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          sram_ce_n;
  logic          fill_done;
  logic          model_en = 1'b0;
  logic [DW-1:0] mem [NPIX];
  logic [DW-1:0] mem_rd;
  int            checks = 0;
  int            errors = 0;

  vga_sram_display_if vga ();

  vga_sram_display #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .PIXEL_DIV(PD),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .vga       (vga),
    .fill_done (fill_done)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: reads follow the address, writes land while we_n is low.
  always_comb mem_rd = (sram_addr[AW-1:AIDX] == '0) ? mem[sram_addr[AIDX-1:0]] : '0;
  assign sram_data = (model_en && !sram_ce_n && !sram_oe_n && sram_we_n) ? mem_rd : 'z;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && (sram_addr[AW-1:AIDX] == '0))
      mem[sram_addr[AIDX-1:0]] <= sram_data;
  end

  function automatic logic [11:0] pattern_rgb(input int x, input int y);
    logic [3:0] r;
    logic [3:0] g;
    r = 4'((x / 8) % 16);
    g = 4'((y / 8) % 16);
    return {r, g, r ^ g};
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y);
    if (x >= HV || y >= VV) return 12'h000;
`ifdef VGA_SRAM_BORDER_EN
    if (x == 0 || x == HV - 1 || y == 0 || y == VV - 1) return 12'hFFF;
`endif
    return pattern_rgb(x, y);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_addr"},  32'(sram_addr), 32'd0);
    checkOutput({tag, "_we_n"},  32'(sram_we_n), 32'd1);
    checkOutput({tag, "_oe_n"},  32'(sram_oe_n), 32'd1);
    checkOutput({tag, "_ce_n"},  32'(sram_ce_n), 32'd1);
    checkOutput({tag, "_hiz"},   32'(sram_data), 32'h0000FFFF);
    checkOutput({tag, "_rgb"},   32'({vga.vga_red, vga.vga_green, vga.vga_blue}), 32'd0);
    checkOutput({tag, "_hsync"}, 32'(vga.vga_hsync), 32'd1);
    checkOutput({tag, "_vsync"}, 32'(vga.vga_vsync), 32'd1);
    checkOutput({tag, "_done"},  32'(fill_done), 32'd0);
  endtask

  task automatic applyStimulus(input int hold_cycles);
    reset_n = 1'b0;
    repeat (hold_cycles) @(negedge clk);
    checkReset("reset");
    reset_n = 1'b1;
  endtask

  // Starts right after reset release; edge n=1 is the first rising edge of the fill.
  task automatic checkFill();
    int p;
    for (int n = 1; n <= 2 * NPIX; n++) begin
      @(posedge clk);
      #1;
      p = (n - 1) / 2;
      checkOutput("fill_we_n", 32'(sram_we_n), (n % 2 == 1) ? 32'd0 : 32'd1);
      checkOutput("fill_ce_n", 32'(sram_ce_n), 32'd0);
      checkOutput("fill_oe_n", 32'(sram_oe_n), 32'd1);
      checkOutput("fill_addr", 32'(sram_addr), 32'(p));
      checkOutput("fill_data", 32'(sram_data), 32'(pattern_rgb(p % HV, p / HV)));
      checkOutput("fill_done_low", 32'(fill_done), 32'd0);
      if (n == 1) checkOutput("first_write_data", 32'(sram_data), 32'h0000);
      if (n % 2 == 1 && p == HV + 1) checkOutput("fill_x1y1", 32'(sram_data), 32'h0000);
      if (n % 2 == 1 && p == 8 * HV + 8) checkOutput("fill_x8y8", 32'(sram_data), 32'h0110);
    end
    @(posedge clk);
    #1;
    checkOutput("fill_done_rise", 32'(fill_done), 32'd1);
    checkOutput("disp_entry_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("disp_entry_oe_n", 32'(sram_oe_n), 32'd0);
    checkOutput("disp_entry_ce_n", 32'(sram_ce_n), 32'd0);
    checkOutput("disp_entry_hiz", 32'(sram_data), 32'h0000FFFF);
    model_en = 1'b1;
  endtask

  // Edge m counts from DISPLAY entry; after tick k (edge k*PD) the outputs show pixel k-1.
  task automatic checkDisplay(input int frames);
    int k;
    int q;
    int x;
    int y;
    int hs_low = 0;
    int vs_low = 0;
    logic [11:0] rgb;
    logic [11:0] exp_rgb;
    logic exp_hs;
    logic exp_vs;
    for (int m = 1; m <= frames * FRAME_EDGES; m++) begin
      @(posedge clk);
      #1;
      k = m / PD;
      if (k == 0) begin
        x = -1; y = -1;
        exp_rgb = 12'h000; exp_hs = 1'b1; exp_vs = 1'b1;
      end else begin
        q = (k - 1) % (HT * VT);
        x = q % HT;
        y = q / HT;
        exp_rgb = model_rgb(x, y);
        exp_hs = !(x >= HV + HF && x < HV + HF + HS);
        exp_vs = !(y >= VV + VF && y < VV + VF + VS);
      end
      rgb = {vga.vga_red, vga.vga_green, vga.vga_blue};
      checkOutput("disp_rgb", 32'(rgb), 32'(exp_rgb));
      checkOutput("disp_hsync", 32'(vga.vga_hsync), 32'(exp_hs));
      checkOutput("disp_vsync", 32'(vga.vga_vsync), 32'(exp_vs));
      checkOutput("disp_we_n", 32'(sram_we_n), 32'd1);
      checkOutput("disp_oe_n", 32'(sram_oe_n), 32'd0);
      if (m % PD == 0) begin
        if (!vga.vga_hsync) hs_low++;
        if (!vga.vga_vsync) vs_low++;
        if (x == 16 && y == 8) checkOutput("rgb_x16y8", 32'(rgb), 32'h213);
`ifdef VGA_SRAM_BORDER_EN
        if (x == 0 && y == 5) checkOutput("rgb_x0y5", 32'(rgb), 32'hFFF);
`else
        if (x == 0 && y == 5) checkOutput("rgb_x0y5", 32'(rgb), 32'h000);
`endif
        if (x == 1 && y == 5) checkOutput("rgb_x1y5", 32'(rgb), 32'h000);
        if (x == HV && y == 8) checkOutput("rgb_blank", 32'(rgb), 32'h000);
      end
    end
    checkOutput("hsync_low_ticks", 32'(hs_low), 32'(frames * VT * HS));
    checkOutput("vsync_low_ticks", 32'(vs_low), 32'(frames * HT * VS));
  endtask

  initial begin
    int abort_at;
    #2;
    applyStimulus(10 + int'($urandom_range(0, 6)));
    abort_at = int'($urandom_range(20, 2 * NPIX - 20));
    repeat (abort_at) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 checkReset("fill_abort");
    applyStimulus(10 + int'($urandom_range(0, 6)));
    checkFill();
    checkDisplay(3);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 checkReset("disp_abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
